// File: rtl/pass_scheduler_pkg.sv
// Shared types for the layer pass scheduler: FSM states,
// layer-type codes and the depthwise halo default.
package pass_scheduler_pkg;

  localparam int unsigned DW_HALO_DEF = 2;

  localparam logic [1:0] LT_CONV      = 2'd0;
  localparam logic [1:0] LT_DEPTHWISE = 2'd1;
  localparam logic [1:0] LT_POINTWISE = 2'd2;
  localparam logic [1:0] LT_FC        = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ADV,
    S_DONE
  } sched_state_e;

endpackage

// File: rtl/tile_geom_calc.sv
// Pass geometry: On_real = min(remaining, tile_max), halo for depthwise.
// Ports: remaining/tile_max/tile_idx/type in; on_real/tile_n/first/last out.
module tile_geom_calc
  import pass_scheduler_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DW_HALO = DW_HALO_DEF
) (
  input  logic [CNT_W-1:0] remaining_i,
  input  logic [CNT_W-1:0] tile_max_i,
  input  logic [CNT_W-1:0] tile_idx_i,
  input  logic [1:0]       layer_type_i,
  output logic [CNT_W-1:0] on_real_o,
  output logic [CNT_W-1:0] tile_n_o,
  output logic             first_o,
  output logic             last_o
);

  always_comb begin
    last_o    = (remaining_i <= tile_max_i);
    on_real_o = last_o ? remaining_i : tile_max_i;
    tile_n_o  = on_real_o;
    if (layer_type_i == LT_DEPTHWISE) begin
      tile_n_o = on_real_o + CNT_W'(DW_HALO);
    end
    first_o   = (tile_idx_i == '0);
  end

endmodule

// File: rtl/pass_scheduler.sv
// Layer sequencer: splits On into passes, issues pass_start, waits for done.
// Ports: layer ctrl/config in, pass geometry + GLB bases + status out.
module pass_scheduler
  import pass_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DW_HALO = DW_HALO_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              layer_start_i,
  input  logic              layer_abort_i,
  input  logic [1:0]        layer_type_i,
  input  logic [CNT_W-1:0]  total_n_i,
  input  logic [CNT_W-1:0]  tile_n_max_i,
  input  logic [ADDR_W-1:0] ifmap_base_i,
  input  logic [ADDR_W-1:0] ipsum_base_i,
  input  logic [ADDR_W-1:0] opsum_base_i,
  input  logic [ADDR_W-1:0] ifmap_stride_i,
  input  logic [ADDR_W-1:0] opsum_stride_i,
  input  logic              pass_done_i,
  output logic              pass_start_o,
  output logic [CNT_W-1:0]  tile_n_o,
  output logic [CNT_W-1:0]  On_real_o,
  output logic              n_tile_is_first_o,
  output logic              n_tile_is_last_o,
  output logic [ADDR_W-1:0] ifmap_GLB_base_addr_o,
  output logic [ADDR_W-1:0] ipsum_GLB_base_addr_o,
  output logic [ADDR_W-1:0] opsum_GLB_base_addr_o,
  output logic [CNT_W-1:0]  tile_idx_o,
  output logic              busy_o,
  output logic              layer_done_o
);

  sched_state_e state_q, state_d;

  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  tmax_q, tmax_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [1:0]        type_q, type_d;
  logic [ADDR_W-1:0] ifa_q, ifa_d;
  logic [ADDR_W-1:0] ipa_q, ipa_d;
  logic [ADDR_W-1:0] opa_q, opa_d;
  logic [ADDR_W-1:0] ifs_q, ifs_d;
  logic [ADDR_W-1:0] ops_q, ops_d;

  logic [CNT_W-1:0]  on_q, tn_q;
  logic              first_q, last_q;
  logic              start_q, done_q, busy_q;
  logic              geom_ld;

  logic [CNT_W-1:0]  g_on, g_tn;
  logic              g_first, g_last;

  // Geometry is computed from next-state counters so it
  // lands in its registers together with the ISSUE state.
  tile_geom_calc #(
    .CNT_W   (CNT_W),
    .DW_HALO (DW_HALO)
  ) u_geom (
    .remaining_i  (rem_d),
    .tile_max_i   (tmax_d),
    .tile_idx_i   (idx_d),
    .layer_type_i (type_d),
    .on_real_o    (g_on),
    .tile_n_o     (g_tn),
    .first_o      (g_first),
    .last_o       (g_last)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tmax_d  = tmax_q;
    idx_d   = idx_q;
    type_d  = type_q;
    ifa_d   = ifa_q;
    ipa_d   = ipa_q;
    opa_d   = opa_q;
    ifs_d   = ifs_q;
    ops_d   = ops_q;
    geom_ld = 1'b0;
    if (layer_abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (layer_start_i) begin
            rem_d  = total_n_i;
            tmax_d = (tile_n_max_i == '0) ? CNT_W'(1) : tile_n_max_i;
            idx_d  = '0;
            type_d = layer_type_i;
            ifa_d  = ifmap_base_i;
            ipa_d  = ipsum_base_i;
            opa_d  = opsum_base_i;
            ifs_d  = ifmap_stride_i;
            ops_d  = opsum_stride_i;
            if (total_n_i == '0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ISSUE;
              geom_ld = 1'b1;
            end
          end
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (pass_done_i) begin
            state_d = last_q ? S_DONE : S_ADV;
          end
        end
        S_ADV: begin
          rem_d   = rem_q - on_q;
          idx_d   = idx_q + CNT_W'(1);
          ifa_d   = ifa_q + ifs_q;
          ipa_d   = ipa_q + ops_q;
          opa_d   = opa_q + ops_q;
          geom_ld = 1'b1;
          state_d = S_ISSUE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      tmax_q  <= '0;
      idx_q   <= '0;
      type_q  <= '0;
      ifa_q   <= '0;
      ipa_q   <= '0;
      opa_q   <= '0;
      ifs_q   <= '0;
      ops_q   <= '0;
      on_q    <= '0;
      tn_q    <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tmax_q  <= tmax_d;
      idx_q   <= idx_d;
      type_q  <= type_d;
      ifa_q   <= ifa_d;
      ipa_q   <= ipa_d;
      opa_q   <= opa_d;
      ifs_q   <= ifs_d;
      ops_q   <= ops_d;
      if (geom_ld) begin
        on_q    <= g_on;
        tn_q    <= g_tn;
        first_q <= g_first;
        last_q  <= g_last;
      end
      start_q <= (state_d == S_ISSUE);
      done_q  <= (state_q == S_DONE) && !layer_abort_i;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign pass_start_o          = start_q;
  assign tile_n_o              = tn_q;
  assign On_real_o             = on_q;
  assign n_tile_is_first_o     = first_q;
  assign n_tile_is_last_o      = last_q;
  assign ifmap_GLB_base_addr_o = ifa_q;
  assign ipsum_GLB_base_addr_o = ipa_q;
  assign opsum_GLB_base_addr_o = opa_q;
  assign tile_idx_o            = idx_q;
  assign busy_o                = busy_q;
  assign layer_done_o          = done_q;

endmodule

// File: doc/pass_scheduler.md
Name: pass_scheduler

Overview:
- Layer-level sequencer in front of token_engine.
- Splits one layer's output extent (On, rows/pixels along n) into passes of at most tile_n_max outputs.
- For each pass it drives pass_start, tile geometry, first/last flags and per-tile GLB base addresses, then waits for pass_done.
- Raises layer_done after the last pass completes.

Parameters:
- ADDR_W, 32, GLB address width.
- CNT_W, 32, width of the extent, tile and index counters.
- DW_HALO, 2, extra input rows a depthwise tile needs beyond its output rows.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- layer_start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- layer_abort_i  in  1  synchronous abort; returns to IDLE.
- layer_type_i  in  2  layer-type code from the shared define header.
- total_n_i  in  CNT_W  total outputs On for the layer.
- tile_n_max_i  in  CNT_W  maximum outputs per pass; 0 is treated as 1.
- ifmap_base_i  in  ADDR_W  ifmap GLB base for tile 0.
- ipsum_base_i  in  ADDR_W  ipsum GLB base for tile 0.
- opsum_base_i  in  ADDR_W  opsum GLB base for tile 0.
- ifmap_stride_i  in  ADDR_W  ifmap address increment per tile.
- opsum_stride_i  in  ADDR_W  opsum/ipsum address increment per tile.
- pass_done_i  in  1  pass-complete pulse from token_engine.
- pass_start_o  out  1  one-cycle pass start.
- tile_n_o  out  CNT_W  tile_n for token_engine.
- On_real_o  out  CNT_W  outputs in the current pass.
- n_tile_is_first_o  out  1  current pass is tile 0.
- n_tile_is_last_o  out  1  current pass is the final tile.
- ifmap_GLB_base_addr_o  out  ADDR_W  current ifmap base.
- ipsum_GLB_base_addr_o  out  ADDR_W  current ipsum base.
- opsum_GLB_base_addr_o  out  ADDR_W  current opsum base.
- tile_idx_o  out  CNT_W  current tile index, 0-based.
- busy_o  out  1  high in every state except IDLE.
- layer_done_o  out  1  one-cycle done pulse.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, ADV, DONE.
- IDLE:
  - On layer_start_i, latch all config.
  - remaining = total_n_i.
  - Addresses = the *_base_i values; tile_idx = 0.
  - If total_n_i == 0, go to DONE (no pass is issued). Otherwise go to ISSUE.
- Pass geometry: On_real = min(remaining, tile_n_max).
  - tile_n = On_real + DW_HALO when layer type is DEPTHWISE; otherwise tile_n = On_real.
  - first = (tile_idx == 0); last = (remaining <= tile_n_max).
  - On_real, tile_n, first and last are registered on the cycle before ISSUE, so they are stable while pass_start_o is high and held until the next ADV.
- ISSUE: pass_start_o = 1 for exactly this cycle, then go to WAIT.
- WAIT: hold all outputs.
  - On pass_done_i: if last, go to DONE; otherwise go to ADV.
  - pass_done_i is ignored in every other state.
- ADV, one cycle:
  - remaining -= On_real; tile_idx += 1.
  - ifmap address += ifmap_stride; ipsum and opsum addresses += opsum_stride.
  - Recompute the pass geometry, then go to ISSUE.
- Latency from pass_done_i to the next pass_start_o is 2 cycles.
- DONE: layer_done_o = 1 for one cycle, busy_o drops, go to IDLE.
  - Geometry outputs keep their last values until the next start.
- Address arithmetic is modulo 2^ADDR_W (wraps, no flag). Counters are unsigned.
- layer_start_i while busy is ignored.
- layer_abort_i has priority over all transitions in any state:
  - Next state is IDLE, pass_start_o = 0.
  - No layer_done_o is generated.
  - Outputs hold their values and busy_o = 0.
- If pass_done_i and layer_abort_i coincide, abort wins.
- Asserting rst_n low mid-layer returns to the reset state immediately; no pulse is emitted.

Decomposition:
- Shared package holds:
  - the FSM state enum (sched_state_e);
  - the DW_HALO default;
  - the layer-type codes, re-exported from the shared define header.
- One natural sub-module, tile_geom_calc: combinational min/halo/last computation, instanced once.

Test Plan:
- POINTWISE, total 100, tile 40, ifmap base 0x1000, ifmap stride 0x500, opsum base 0x3000, opsum stride 0xA00 -> 3 passes:
  - On_real 40/40/20 and tile_n 40/40/20;
  - first only on tile 0, last only on tile 2;
  - ifmap bases 0x1000/0x1500/0x1A00, opsum bases 0x3000/0x3A00/0x4400;
  - exactly one layer_done_o.
- DEPTHWISE, total 5, tile 2 -> On_real 2/2/1 and tile_n 4/4/3; tile 1 has first = 0 and last = 0.
- total 0 -> no pass_start_o; layer_done_o 2 cycles after layer_start_i.
- tile_n_max 0, total 3 -> 3 passes of On_real 1.
- pass_done_i in IDLE, and layer_start_i pulses in WAIT -> no state change and no extra pass_start_o.
- layer_abort_i asserted in WAIT during tile 1 of 3 -> next cycle IDLE, busy_o 0, no layer_done_o; a new start restarts at tile 0 with base addresses.
